// File: rtl/uart_rx_sampler_if.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler_if
//   Bundles the serial line, the byte handshake and the status flags of the
//   UART receiver so the receiver and its consumer share one port.
//
//   uart_rx    serial line, idle high (driven by the line side / consumer)
//   rx_ack     consumer acknowledge, clears rx_valid
//   rx_data    last good byte, LSB received first
//   rx_valid   rx_data holds an unconsumed byte
//   overrun    sticky, a byte completed while the previous was unconsumed
//   frame_err  one-sysclk pulse on a bad stop bit
//   busy       receiver is somewhere other than IDLE
//
//   master : the consumer side (drives line and acknowledge)
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_sampler_if;
    logic       uart_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    modport master (
        output uart_rx,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  overrun,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  uart_rx,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output overrun,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//   8N1 UART receiver with 16x oversampling and mid-bit sampling. A falling
//   edge is confirmed at the middle of the start bit (short glitches are
//   dropped), each data bit is sampled one bit time later, and the stop bit
//   is checked at its middle. A low stop bit pulses frame_err and parks the
//   receiver in BREAK until the line returns high, so a held-low line does
//   not retrigger a frame every bit time.
//
//   Ports:
//     sysclk   system clock
//     reset    asynchronous, active-low
//     bus      uart_rx_sampler_if.slave (line, handshake, status flags)
//
//   Parameters:
//     TICK_DIV    sysclk cycles per oversample tick (>= 2)
//     OVERSAMPLE  ticks per bit, even and >= 8
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int TICK_DIV   = 326,
    parameter int OVERSAMPLE = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    uart_rx_sampler_if.slave  bus
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = ($clog2(OVERSAMPLE) > 4) ? $clog2(OVERSAMPLE) : 4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e             state_q,     state_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [CNT_W-1:0]   sampleCnt_q, sampleCnt_d;
    logic [2:0]         bitIdx_q,    bitIdx_d;
    logic [7:0]         shift_q,     shift_d;
    logic [7:0]         rxData_q,    rxData_d;
    logic               rxValid_q,   rxValid_d;
    logic               overrun_q,   overrun_d;
    logic               frameErr_q,  frameErr_d;
    logic [1:0]         rxSync_q;

    logic               tick;
    logic               rxs;

    assign tick = (div_q == DIV_LAST);
    assign rxs  = rxSync_q[1];

    // Free-running oversample divider; it never stops, so the tick phase is
    // independent of the line and the start-edge detection jitters by up to
    // one tick.
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Frame sequencing. Every state action is gated by the tick; only the
    // acknowledge is honoured on any sysclk. The counter is cleared whenever
    // a state is entered and after each data sample, so the data and stop
    // samples land a whole bit after the mid-start decision, i.e. mid-bit.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        rxData_d    = rxData_q;
        rxValid_d   = rxValid_q;
        overrun_d   = overrun_q;
        frameErr_d  = 1'b0;

        if (bus.rx_ack) begin
            rxValid_d = 1'b0;
        end

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d     = START;
                        sampleCnt_d = '0;
                    end
                end

                START: begin
                    if (sampleCnt_q == CNT_MID) begin
                        sampleCnt_d = '0;
                        if (!rxs) begin
                            state_d  = DATA;
                            bitIdx_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (sampleCnt_q == CNT_LAST) begin
                        // Shifting in at the MSB leaves the first bit in bit 0.
                        shift_d     = {rxs, shift_q[7:1]};
                        sampleCnt_d = '0;
                        bitIdx_d    = bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (sampleCnt_q == CNT_LAST) begin
                        sampleCnt_d = '0;
                        if (rxs) begin
                            rxData_d  = shift_q;
                            rxValid_d = 1'b1;
                            // An ack landing on the completion cycle consumed
                            // the old byte, so nothing was lost.
                            if (rxValid_q && !bus.rx_ack) begin
                                overrun_d = 1'b1;
                            end
                            state_d = IDLE;
                        end else begin
                            frameErr_d = 1'b1;
                            state_d    = BREAK;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + CNT_W'(1);
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state_d     = IDLE;
                        sampleCnt_d = '0;
                    end
                end

                default: begin
                    state_d     = IDLE;
                    sampleCnt_d = '0;
                end
            endcase
        end
    end

    // State registers plus the two-flop line synchronizer, which resets to
    // the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            sampleCnt_q <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            rxSync_q    <= 2'b11;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sampleCnt_q <= sampleCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            rxData_q    <= rxData_d;
            rxValid_q   <= rxValid_d;
            overrun_q   <= overrun_d;
            frameErr_q  <= frameErr_d;
            rxSync_q    <= {rxSync_q[0], bus.uart_rx};
        end
    end

    assign bus.rx_data   = rxData_q;
    assign bus.rx_valid  = rxValid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frameErr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//   Bench for uart_rx_sampler. A short tick divider keeps frames at 64 sysclk
//   per bit. The stimulus serialises bytes onto the line and records each
//   frame's start cycle; a monitor keeps a byte-level model (expected bytes
//   in order, latest good byte, valid, sticky overrun) and compares the DUT
//   against it on every cycle. Completion must land 9.5 nominal bit times
//   after the start edge, plus synchronizer delay and up to one tick.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int TD     = 4;
    localparam int OS     = 16;
    localparam int NOM    = TD * OS;
    localparam int LAT_LO = TD * (9 * OS + OS / 2);
    localparam int LAT_HI = LAT_LO + TD + 6;

    logic sysclk;
    logic reset;

    uart_rx_sampler_if ifc ();

    uart_rx_sampler #(
        .TICK_DIV   (TD),
        .OVERSAMPLE (OS)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (ifc)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] expByte [64];
    int         expEdge [64];
    int         nExp = 0;
    int         badEdge [16];
    int         nBad = 0;
    int         rdIdx = 0;
    int         badRd = 0;

    bit autoAck = 1'b0;
    int ackReqs = 0;
    int ackDone = 0;

    // 100 MHz-style clock; only the cycle count matters here.
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Sends the first nBits bits of an 8N1 frame (10 = whole frame). The
    // line is left at the last bit sent. Whole frames are recorded for the
    // monitor: good stop bit as an expected byte, low stop bit as an
    // expected frame error.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int bitCycles, input int nBits);
        logic b;
        for (int i = 0; i < nBits; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i <= 8) b = data[i-1];
            else             b = stopBit;
            ifc.uart_rx = b;
            if (i == 0 && nBits == 10) begin
                if (stopBit) begin
                    expByte[nExp] = data;
                    expEdge[nExp] = cyc;
                    nExp++;
                end else begin
                    badEdge[nBad] = cyc;
                    nBad++;
                end
            end
            repeat (bitCycles) @(negedge sysclk);
        end
    endtask

    task automatic ackOnce();
        ackReqs++;
        repeat (4) @(negedge sysclk);
    endtask

    // Sole driver of rx_ack: explicit one-cycle requests, or an immediate
    // ack of every byte while autoAck is set.
    initial begin
        ifc.rx_ack = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            if (ackReqs != ackDone) begin
                ifc.rx_ack = 1'b1;
                ackDone++;
            end else begin
                ifc.rx_ack = autoAck && ifc.rx_valid && !ifc.rx_ack;
            end
        end
    end

    // Byte-level reference model and per-cycle compare.
    initial begin
        logic       expValid;
        logic       expOverrun;
        logic [7:0] expData;
        logic       ackPend;
        logic       prevValid;
        logic [7:0] prevData;
        logic       completion;
        expValid = 1'b0; expOverrun = 1'b0; expData = '0;
        ackPend = 1'b0; prevValid = 1'b0; prevData = '0;
        forever begin
            @(negedge sysclk);
            if (!reset) begin
                expValid   = 1'b0;
                expOverrun = 1'b0;
                expData    = '0;
                ackPend    = 1'b0;
                prevValid  = 1'b0;
                prevData   = '0;
                rdIdx      = nExp;
                badRd      = nBad;
                checkOutput("reset rx_valid",  ifc.rx_valid,  0);
                checkOutput("reset rx_data",   ifc.rx_data,   0);
                checkOutput("reset overrun",   ifc.overrun,   0);
                checkOutput("reset frame_err", ifc.frame_err, 0);
                checkOutput("reset busy",      ifc.busy,      0);
            end else begin
                completion = (ifc.rx_valid && !prevValid) || (ifc.rx_data !== prevData);
                if (completion) begin
                    checkOutput("frame expected", rdIdx < nExp, 1);
                    if (rdIdx < nExp) begin
                        checkOutput("frame data", ifc.rx_data, expByte[rdIdx]);
                        checkOutput("frame latency",
                                    (cyc >= expEdge[rdIdx] + LAT_LO) && (cyc <= expEdge[rdIdx] + LAT_HI), 1);
                        if (expValid && !ackPend) expOverrun = 1'b1;
                        expValid = 1'b1;
                        expData  = expByte[rdIdx];
                        rdIdx++;
                    end
                end else if (ackPend) begin
                    expValid = 1'b0;
                end
                if (rdIdx < nExp && cyc > expEdge[rdIdx] + LAT_HI) begin
                    checkOutput("frame arrived in time", cyc <= expEdge[rdIdx] + LAT_HI, 1);
                    rdIdx++;
                end

                if (ifc.frame_err) begin
                    checkOutput("frame_err expected", badRd < nBad, 1);
                    if (badRd < nBad) begin
                        checkOutput("frame_err latency",
                                    (cyc >= badEdge[badRd] + LAT_LO) && (cyc <= badEdge[badRd] + LAT_HI), 1);
                        badRd++;
                    end
                end
                if (badRd < nBad && cyc > badEdge[badRd] + LAT_HI) begin
                    checkOutput("frame_err arrived in time", cyc <= badEdge[badRd] + LAT_HI, 1);
                    badRd++;
                end

                checkOutput("rx_valid", ifc.rx_valid, expValid);
                checkOutput("rx_data",  ifc.rx_data,  expData);
                checkOutput("overrun",  ifc.overrun,  expOverrun);

                ackPend   = ifc.rx_ack;
                prevValid = ifc.rx_valid;
                prevData  = ifc.rx_data;
            end
        end
    end

    initial begin
        ifc.uart_rx = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (5) @(negedge sysclk);
        checkOutput("init rx_valid",  ifc.rx_valid,  0);
        checkOutput("init rx_data",   ifc.rx_data,   8'h00);
        checkOutput("init overrun",   ifc.overrun,   0);
        checkOutput("init frame_err", ifc.frame_err, 0);
        checkOutput("init busy",      ifc.busy,      0);
        @(posedge sysclk);
        #2 reset = 1'b1;
        repeat (3 * NOM) @(negedge sysclk);

        // Single frame 0x05.
        applyStimulus(8'h05, 1'b1, NOM, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t1 rx_data",  ifc.rx_data,  8'h05);
        checkOutput("t1 rx_valid", ifc.rx_valid, 1);
        ackOnce();
        checkOutput("t1 acked rx_valid", ifc.rx_valid, 0);

        // Back-to-back 0x98, 0xFF with immediate acks.
        autoAck = 1'b1;
        applyStimulus(8'h98, 1'b1, NOM, 10);
        applyStimulus(8'hFF, 1'b1, NOM, 10);
        repeat (2 * NOM) @(negedge sysclk);
        autoAck = 1'b0;
        checkOutput("t2 rx_data",  ifc.rx_data,  8'hFF);
        checkOutput("t2 rx_valid", ifc.rx_valid, 0);
        checkOutput("t2 overrun",  ifc.overrun,  0);

        // Three-tick low glitch on the idle line.
        checkOutput("t3 busy before", ifc.busy, 0);
        ifc.uart_rx = 1'b0;
        repeat (TD + 4) @(negedge sysclk);
        checkOutput("t3 busy in glitch", ifc.busy, 1);
        repeat (3 * TD - (TD + 4)) @(negedge sysclk);
        ifc.uart_rx = 1'b1;
        repeat (9 * TD) @(negedge sysclk);
        checkOutput("t3 busy after", ifc.busy, 0);
        checkOutput("t3 rx_valid",   ifc.rx_valid, 0);

        // 0x5A with a low stop bit, line held low, then 0x33.
        applyStimulus(8'h5A, 1'b0, NOM, 10);
        repeat (3 * NOM) @(negedge sysclk);
        checkOutput("t4 busy in break", ifc.busy, 1);
        checkOutput("t4 rx_data kept",  ifc.rx_data, 8'hFF);
        ifc.uart_rx = 1'b1;
        repeat (2 * TD + 4) @(negedge sysclk);
        checkOutput("t4 busy released", ifc.busy, 0);
        repeat (NOM) @(negedge sysclk);
        applyStimulus(8'h33, 1'b1, NOM, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t4 rx_data", ifc.rx_data, 8'h33);
        ackOnce();

        // Two frames without ack: overrun, sticky across a later ack.
        applyStimulus(8'h11, 1'b1, NOM, 10);
        applyStimulus(8'h22, 1'b1, NOM, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t5 rx_data", ifc.rx_data, 8'h22);
        checkOutput("t5 overrun", ifc.overrun, 1);
        ackOnce();
        checkOutput("t5 overrun sticky", ifc.overrun,  1);
        checkOutput("t5 rx_valid",       ifc.rx_valid, 0);

        // Reset in the middle of data bit 4, then 0xA5 after an idle frame.
        applyStimulus(8'h6C, 1'b1, NOM, 5);
        ifc.uart_rx = 1'b0;
        repeat (NOM / 2) @(negedge sysclk);
        checkOutput("t6 busy mid frame", ifc.busy, 1);
        @(posedge sysclk);
        #2;
        reset = 1'b0;
        ifc.uart_rx = 1'b1;
        repeat (4) @(negedge sysclk);
        checkOutput("t6 reset overrun", ifc.overrun, 0);
        checkOutput("t6 reset busy",    ifc.busy,    0);
        @(posedge sysclk);
        #2 reset = 1'b1;
        repeat (11 * NOM) @(negedge sysclk);
        applyStimulus(8'hA5, 1'b1, NOM, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t6 rx_data",  ifc.rx_data,  8'hA5);
        checkOutput("t6 rx_valid", ifc.rx_valid, 1);
        checkOutput("t6 overrun",  ifc.overrun,  0);
        ackOnce();

        // About 3% slow and 3% fast line rates.
        applyStimulus(8'h3C, 1'b1, NOM + 2, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t7 slow rx_data", ifc.rx_data, 8'h3C);
        ackOnce();
        applyStimulus(8'hC3, 1'b1, NOM - 2, 10);
        repeat (2 * NOM) @(negedge sysclk);
        checkOutput("t7 fast rx_data", ifc.rx_data, 8'hC3);
        ackOnce();

        repeat (NOM) @(negedge sysclk);
        checkOutput("all frames seen",       rdIdx, nExp);
        checkOutput("all frame errors seen", badRd, nBad);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
